// File: rtl/fanctrl_pkg.sv
// Shared fan-control definitions: capture FSM states, counter width
// defaults and the all-ones saturation helper.
package fanctrl_pkg;

  localparam int unsigned CNT_BITWIDTH_DEF = 8;
  localparam int unsigned SYNC_STAGES_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } cap_state_e;

  // Largest value a counter of the given width can hold.
  function automatic int unsigned cnt_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  localparam int unsigned CNT_MAX_DEF = cnt_max(CNT_BITWIDTH_DEF);

endpackage

// File: rtl/pwm_capture_if.sv
// Result bundle of the PWM capture block: measured period/high time,
// report strobe, stuck flag and synchronized line level.
interface pwm_capture_if
  import fanctrl_pkg::*;
#(
  parameter int unsigned W = CNT_BITWIDTH_DEF
);
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         valid_o;
  logic         stuck_o;
  logic         level_o;

  modport master (output period_o, high_o, valid_o, stuck_o, level_o);
  modport slave  (input  period_o, high_o, valid_o, stuck_o, level_o);
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a previous-level flop; rise/fall are
// suppressed until the whole pipeline has been refilled after reset.
module sync_edge_detect
  import fanctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   primed_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // primed_q fills with ones; its top bit rises once prev_q holds real data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q   <= sync_lvl;
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise_o  = primed_q[SYNC_STAGES] &  sync_lvl & ~prev_q;
  assign fall_o  = primed_q[SYNC_STAGES] & ~sync_lvl &  prev_q;
  assign level_o = sync_lvl;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM in clock cycles and
// flags a line that has stopped toggling.
module pwm_capture
  import fanctrl_pkg::*;
#(
  parameter int unsigned CNT_BITWIDTH = CNT_BITWIDTH_DEF,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pwm_i,
  pwm_capture_if.master    cap_if
);

  localparam int unsigned           CNT_MAX_I = cnt_max(CNT_BITWIDTH);
  localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = CNT_MAX_I[CNT_BITWIDTH-1:0];
  localparam logic [CNT_BITWIDTH-1:0] ONE     = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};

  logic rise;
  logic fall;
  logic level;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (pwm_i),
    .rise_o  (rise),
    .fall_o  (fall),
    .level_o (level)
  );

  cap_state_e              state_q, state_d;
  logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_BITWIDTH-1:0] hi_q, hi_d;
  logic [CNT_BITWIDTH-1:0] period_q, period_d;
  logic [CNT_BITWIDTH-1:0] high_q, high_d;
  logic                    valid_q, valid_d;
  logic                    stuck_q, stuck_d;

  logic                    at_max;
  logic [CNT_BITWIDTH-1:0] hi_inc;
  logic [CNT_BITWIDTH-1:0] timeout_high;

  assign at_max       = (cnt_q == CNT_MAX);
  assign hi_inc       = {{(CNT_BITWIDTH-1){1'b0}}, level};
  assign timeout_high = level ? CNT_MAX : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  // A rise always takes precedence over the timeout, so a period of exactly
  // CNT_MAX is reported normally. Counters saturate by entering STUCK.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = ONE;
          hi_d    = ONE;
        end else if (at_max) begin
          state_d  = STUCK;
          period_d = CNT_MAX;
          high_d   = timeout_high;
          valid_d  = 1'b1;
          stuck_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_q;
          valid_d  = 1'b1;
          stuck_d  = 1'b0;
          cnt_d    = ONE;
          hi_d     = ONE;
        end else if (at_max) begin
          state_d  = STUCK;
          period_d = CNT_MAX;
          high_d   = timeout_high;
          valid_d  = 1'b1;
          stuck_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
          hi_d  = hi_q + hi_inc;
        end
      end
      STUCK: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = ONE;
          hi_d    = ONE;
        end else if (fall) begin
          high_d  = '0;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cap_if.period_o = period_q;
  assign cap_if.high_o   = high_q;
  assign cap_if.valid_o  = valid_q;
  assign cap_if.stuck_o  = stuck_q;
  assign cap_if.level_o  = level;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: PWM trains push expected reports,
// a negedge monitor pops and compares each valid_o pulse.
module tb_pwm_capture;
  import fanctrl_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_i;
  logic pwm_i;

  pwm_capture_if #(.W(W)) cap_if ();

  pwm_capture #(
    .CNT_BITWIDTH (W),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .pwm_i  (pwm_i),
    .cap_if (cap_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
    int stuck;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   mark_cyc = 0;

  int   prev_p;
  int   prev_h;
  bit   prev_valid;
  bit   prev_reported;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int p, input int h, input int s, input int g);
    exp_t e;
    e.period = p;
    e.high   = h;
    e.stuck  = s;
    e.gap    = g;
    exp_q.push_back(e);
  endtask

  task automatic clear_model();
    exp_q.delete();
    prev_valid    = 1'b0;
    prev_reported = 1'b0;
  endtask

  task automatic monitor_loop();
    exp_t e;
    logic [W-1:0] ep, eh;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b0 && cap_if.valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: period=%0d high=%0d stuck=%0d, required no report",
                   cap_if.period_o, cap_if.high_o, cap_if.stuck_o);
        end else begin
          e  = exp_q.pop_front();
          ep = e.period[W-1:0];
          eh = e.high[W-1:0];
          checks++;
          if (cap_if.period_o !== ep) begin
            errors++;
            $display("FAIL period: got %0d required %0d", cap_if.period_o, ep);
          end
          checks++;
          if (cap_if.high_o !== eh) begin
            errors++;
            $display("FAIL high: got %0d required %0d", cap_if.high_o, eh);
          end
          checks++;
          if (cap_if.stuck_o !== e.stuck[0]) begin
            errors++;
            $display("FAIL stuck: got %0b required %0b", cap_if.stuck_o, e.stuck[0]);
          end
          if (e.gap != 0) begin
            checks++;
            if (cyc - mark_cyc != e.gap) begin
              errors++;
              $display("FAIL report_gap: got %0d cycles required %0d", cyc - mark_cyc, e.gap);
            end
          end
          $display("report period=%0d high=%0d stuck=%0b at cycle %0d",
                   cap_if.period_o, cap_if.high_o, cap_if.stuck_o, cyc);
        end
        mark_cyc = cyc;
      end
    end
  endtask

  // Model: the rise starting this period completes the previous one.
  task automatic send_period(input int p, input int h);
    if (prev_valid) push_exp(prev_p, prev_h, 0, prev_reported ? prev_p : 0);
    prev_reported = prev_valid;
    prev_valid    = 1'b1;
    prev_p        = p;
    prev_h        = h;
    pwm_i = 1'b1;
    repeat (h) tick();
    pwm_i = 1'b0;
    repeat (p - h) tick();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d reports still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (cap_if.period_o !== '0) begin errors++; $display("FAIL reset_period: got %0d required 0", cap_if.period_o); end
    if (cap_if.high_o   !== '0) begin errors++; $display("FAIL reset_high: got %0d required 0", cap_if.high_o); end
    if (cap_if.valid_o  !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", cap_if.valid_o); end
    if (cap_if.stuck_o  !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %0b required 0", cap_if.stuck_o); end
    if (cap_if.level_o  !== 1'b0) begin errors++; $display("FAIL reset_level: got %0b required 0", cap_if.level_o); end
    $display("reset outputs checked");
    tick();
    rst_i = 1'b0;
    clear_model();
    repeat (5) tick();
  endtask

  task automatic test_level();
    pwm_i = 1'b1;
    tick();
    checks++;
    if (cap_if.level_o !== 1'b0) begin errors++; $display("FAIL level_early: got %0b required 0", cap_if.level_o); end
    tick();
    checks++;
    if (cap_if.level_o !== 1'b1) begin errors++; $display("FAIL level_sync: got %0b required 1", cap_if.level_o); end
    repeat (5) tick();
    pwm_i = 1'b0;
    repeat (11) tick();
    prev_valid    = 1'b1;
    prev_reported = 1'b0;
    prev_p        = 18;
    prev_h        = 7;
    $display("level sync checked");
  endtask

  task automatic test_steady();
    for (int i = 0; i < 5; i++) send_period(18, 7);
    drain("steady_drain", 20);
  endtask

  task automatic test_duty_step();
    for (int i = 0; i < 3; i++) send_period(18, 3);
    for (int i = 0; i < 3; i++) send_period(18, 15);
    drain("duty_drain", 20);
  endtask

  task automatic test_full_period();
    send_period(255, 100);
    send_period(255, 100);
    send_period(18, 7);
    drain("full_period_drain", 20);
  endtask

  task automatic test_timeout_low();
    push_exp(255, 0, 1, prev_reported ? 255 : 0);
    prev_valid    = 1'b0;
    prev_reported = 1'b0;
    pwm_i = 1'b0;
    repeat (300) tick();
    drain("timeout_low_drain", 10);
    send_period(10, 4);
    checks++;
    if (cap_if.stuck_o !== 1'b1) begin errors++; $display("FAIL stuck_hold_low: got %0b required 1", cap_if.stuck_o); end
    send_period(10, 4);
    send_period(10, 4);
    drain("recover_low_drain", 20);
  endtask

  task automatic test_reset_mid();
    send_period(18, 7);
    send_period(18, 7);
    pwm_i = 1'b1;
    drain("pre_reset_drain", 20);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clear_model();
    @(negedge clk);
    checks += 4;
    if (cap_if.period_o !== '0) begin errors++; $display("FAIL midreset_period: got %0d required 0", cap_if.period_o); end
    if (cap_if.high_o   !== '0) begin errors++; $display("FAIL midreset_high: got %0d required 0", cap_if.high_o); end
    if (cap_if.valid_o  !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b required 0", cap_if.valid_o); end
    if (cap_if.stuck_o  !== 1'b0) begin errors++; $display("FAIL midreset_stuck: got %0b required 0", cap_if.stuck_o); end
    $display("mid-period reset checked");
    tick();
    repeat (4) tick();
    pwm_i = 1'b0;
    repeat (11) tick();
    send_period(18, 7);
    send_period(18, 7);
    send_period(18, 7);
    drain("post_reset_drain", 20);
  endtask

  task automatic test_stuck_high();
    pwm_i = 1'b1;
    rst_i = 1'b1;
    repeat (4) tick();
    rst_i = 1'b0;
    clear_model();
    mark_cyc = cyc;
    push_exp(255, 255, 1, 256);
    drain("stuck_high_drain", 300);
    mark_cyc = cyc;
    push_exp(255, 0, 1, 3);
    pwm_i = 1'b0;
    drain("stuck_fall_drain", 10);
    repeat (10) tick();
    send_period(10, 4);
    checks++;
    if (cap_if.stuck_o !== 1'b1) begin errors++; $display("FAIL stuck_hold_high: got %0b required 1", cap_if.stuck_o); end
    send_period(10, 4);
    send_period(10, 4);
    drain("recover_high_drain", 20);
  endtask

  initial begin
    rst_i = 1'b1;
    pwm_i = 1'b0;
    clear_model();
    fork
      monitor_loop();
    join_none
    repeat (3) tick();
    test_reset();
    test_level();
    test_steady();
    test_duty_step();
    test_full_period();
    test_timeout_low();
    test_reset_mid();
    test_stuck_high();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
